mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the core's instruction-fetch port and its data (load/store) port.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data ports; one transaction in flight, data first with fetch starvation bound.
// Grant takes one IDLE cycle, response strobes combinationally with mem_ack; requesters hold req until their valid (no other backpressure).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we_re,
  input  logic [3:0]        d_mask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we_re,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy_fetch
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    starve_cnt_q;
  logic [CNT_W-1:0]    starve_cnt_d;
  logic                mem_req_q;
  logic                mem_we_re_q;
  logic [3:0]          mem_mask_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic starve_ok;
  logic d_grant;
  logic i_grant;

  // A limit of zero disables fairness entirely: data always wins.
  assign starve_ok = (STARVE_LIMIT == 0) || (starve_cnt_q < LIMIT);
  assign d_grant   = (state_q == IDLE) && d_req && (!i_req || starve_ok);
  assign i_grant   = (state_q == IDLE) && i_req && !d_grant;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (d_grant) begin
      if (i_req) begin
        starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end else if (i_grant) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_re_q  <= 1'b0;
      mem_mask_q   <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      case (state_q)
        IDLE: begin
          if (d_grant) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_re_q <= d_we_re;
            mem_mask_q  <= d_mask;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (i_grant) begin
            state_q     <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_re_q <= 1'b0;
            mem_mask_q  <= 4'hF;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // Address/data registers keep their last value after completion.
          if (mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we_re  = mem_we_re_q;
  assign mem_mask   = mem_mask_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy_fetch = (state_q == BUSY_I);

  // Acks outside a transaction never reach either requester.
  assign i_valid = (state_q == BUSY_I) && mem_ack;
  assign d_valid = (state_q == BUSY_D) && mem_ack;
  assign i_rdata = i_valid ? mem_rdata : '0;
  assign d_rdata = d_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single transactions plus hand sequences for collision, stray ack, reset and strict priority.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] i_addr;
  logic        d_we_re;
  logic [3:0]  d_mask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        a_i_req, a_d_req, a_i_valid, a_d_valid, a_mem_req, a_mem_we_re, a_busy_fetch;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_mask;
  logic        a_ack_auto, a_ack_man, a_auto, a_mem_ack;
  logic [31:0] a_mem_rdata;
  int          a_lat, a_cnt;
  logic        a_prev_req;

  logic        b_i_req, b_d_req, b_i_valid, b_d_valid, b_mem_req, b_mem_we_re, b_busy_fetch;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_mask;
  logic        b_mem_ack;
  logic [31:0] b_mem_rdata;
  logic        b_prev_req;
  int          b_gi, b_gd, b_iv, b_dv;

  assign a_mem_ack = a_auto ? a_ack_auto : a_ack_man;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(i_addr), .i_valid(a_i_valid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we_re(d_we_re), .d_mask(d_mask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(a_d_valid), .d_rdata(a_d_rdata),
    .mem_req(a_mem_req), .mem_we_re(a_mem_we_re), .mem_mask(a_mem_mask), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata), .busy_fetch(a_busy_fetch)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(0)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(i_addr), .i_valid(b_i_valid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we_re(d_we_re), .d_mask(d_mask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(b_d_valid), .d_rdata(b_d_rdata),
    .mem_req(b_mem_req), .mem_we_re(b_mem_we_re), .mem_mask(b_mem_mask), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .busy_fetch(b_busy_fetch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fetch;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        fetch;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        e_we;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata;
  } vec_t;

  txn_t exp_q[$];
  txn_t cur;
  logic cur_active;
  int   ncompl;
  int   checks;
  int   errors;
  vec_t vecs[6];

  function automatic logic [31:0] rdfn(input logic [31:0] addr);
    return addr ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic on_grant();
    chk("prev_txn_done", {31'b0, cur_active}, 32'd0);
    chk("grant_expected", {31'b0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      cur_active = 1'b1;
      chk("grant_port", {31'b0, a_busy_fetch}, {31'b0, cur.fetch});
      chk("mem_we_re", {31'b0, a_mem_we_re}, {31'b0, cur.we});
      chk("mem_mask", {28'b0, a_mem_mask}, {28'b0, cur.mask});
      chk("mem_addr", a_mem_addr, cur.addr);
      chk("mem_wdata", a_mem_wdata, cur.wdata);
    end
  endtask

  task automatic on_valid();
    chk("valid_exclusive", {31'b0, a_i_valid & a_d_valid}, 32'd0);
    chk("valid_has_txn", {31'b0, cur_active}, 32'd1);
    if (cur_active) begin
      chk("valid_port", {31'b0, a_i_valid}, {31'b0, cur.fetch});
      if (!cur.we) chk("rdata", cur.fetch ? a_i_rdata : a_d_rdata, rdfn(cur.addr));
      cur_active = 1'b0;
      ncompl++;
    end
  endtask

  // One clock: registered outputs checked at +1, memory models respond, combinational strobes checked at +2.
  task automatic tick();
    @(posedge clk);
    #1;
    if (a_mem_req && !a_prev_req) begin
      on_grant();
    end else if (a_mem_req && cur_active) begin
      chk("hold_addr", a_mem_addr, cur.addr);
      chk("hold_mask", {28'b0, a_mem_mask}, {28'b0, cur.mask});
      chk("hold_wdata", a_mem_wdata, cur.wdata);
      chk("hold_we", {31'b0, a_mem_we_re}, {31'b0, cur.we});
    end
    a_prev_req = a_mem_req;
    if (b_mem_req && !b_prev_req) begin
      if (b_busy_fetch) b_gi++;
      else b_gd++;
    end
    b_prev_req = b_mem_req;
    if (a_mem_req) begin
      a_ack_auto = (a_cnt == a_lat);
      a_cnt++;
    end else begin
      a_ack_auto = 1'b0;
      a_cnt = 0;
    end
    a_mem_rdata = rdfn(a_mem_addr);
    b_mem_ack   = b_mem_req;
    b_mem_rdata = rdfn(b_mem_addr);
    #1;
    if (a_i_valid || a_d_valid) on_valid();
    if (b_d_valid) b_dv++;
    if (b_i_valid) b_iv++;
  endtask

  task automatic wait_compl(input int target, input int budget);
    int n;
    n = 0;
    while (ncompl < target && n < budget) begin
      tick();
      n++;
    end
    chk("completed_in_budget", {31'b0, ncompl >= target}, 32'd1);
  endtask

  task automatic push_txn(input logic f, input logic we, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] w);
    txn_t t;
    t.fetch = f; t.we = we; t.mask = m; t.addr = a; t.wdata = w;
    exp_q.push_back(t);
  endtask

  initial begin
    checks = 0; errors = 0; ncompl = 0; cur_active = 1'b0;
    rst = 1'b1;
    i_addr = '0; d_we_re = 1'b0; d_mask = '0; d_addr = '0; d_wdata = '0;
    a_i_req = 1'b0; a_d_req = 1'b0; a_ack_auto = 1'b0; a_ack_man = 1'b0; a_auto = 1'b1;
    a_mem_rdata = '0; a_lat = 0; a_cnt = 0; a_prev_req = 1'b0;
    b_i_req = 1'b0; b_d_req = 1'b0; b_mem_ack = 1'b0; b_mem_rdata = '0; b_prev_req = 1'b0;
    b_gi = 0; b_gd = 0; b_iv = 0; b_dv = 0;

    vecs[0] = '{fetch:1'b1, we:1'b1, mask:4'h3, addr:32'h0000_0100, wdata:32'hCAFE_F00D, lat:3,
                e_we:1'b0, e_mask:4'hF, e_wdata:32'h0};
    vecs[1] = '{fetch:1'b0, we:1'b1, mask:4'h3, addr:32'h0000_2004, wdata:32'hDEAD_BEEF, lat:2,
                e_we:1'b1, e_mask:4'h3, e_wdata:32'hDEAD_BEEF};
    vecs[2] = '{fetch:1'b0, we:1'b0, mask:4'hF, addr:32'h0000_3000, wdata:32'h1111_2222, lat:0,
                e_we:1'b0, e_mask:4'hF, e_wdata:32'h1111_2222};
    vecs[3] = '{fetch:1'b1, we:1'b0, mask:4'h0, addr:32'h0000_0104, wdata:32'h0, lat:0,
                e_we:1'b0, e_mask:4'hF, e_wdata:32'h0};
    vecs[4] = '{fetch:1'b0, we:1'b0, mask:4'h8, addr:32'h0000_0044, wdata:32'h0, lat:1,
                e_we:1'b0, e_mask:4'h8, e_wdata:32'h0};
    vecs[5] = '{fetch:1'b0, we:1'b1, mask:4'hF, addr:32'hFFFF_FFFC, wdata:32'h1234_5678, lat:4,
                e_we:1'b1, e_mask:4'hF, e_wdata:32'h1234_5678};

    tick(); tick();
    chk("rst_mem_req", {31'b0, a_mem_req}, 32'd0);
    chk("rst_mem_addr", a_mem_addr, 32'd0);
    chk("rst_mem_wdata", a_mem_wdata, 32'd0);
    chk("rst_mem_mask", {28'b0, a_mem_mask}, 32'd0);
    chk("rst_mem_we_re", {31'b0, a_mem_we_re}, 32'd0);
    chk("rst_busy_fetch", {31'b0, a_busy_fetch}, 32'd0);
    chk("rst_valids", {30'b0, a_i_valid, a_d_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {31'b0, a_mem_req}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      if (vecs[k].fetch) i_addr = vecs[k].addr;
      else d_addr = vecs[k].addr;
      d_we_re = vecs[k].we;
      d_mask  = vecs[k].mask;
      d_wdata = vecs[k].wdata;
      a_lat   = vecs[k].lat;
      push_txn(vecs[k].fetch, vecs[k].e_we, vecs[k].e_mask, vecs[k].addr, vecs[k].e_wdata);
      a_i_req = vecs[k].fetch;
      a_d_req = !vecs[k].fetch;
      wait_compl(ncompl + 1, 20);
      a_i_req = 1'b0;
      a_d_req = 1'b0;
      tick(); tick();
      chk("vec_drained", exp_q.size(), 32'd0);
    end

    // Stray ack in IDLE.
    a_auto = 1'b0;
    a_ack_man = 1'b1;
    #1;
    chk("stray_ack_no_valid", {30'b0, a_i_valid, a_d_valid}, 32'd0);
    tick();
    chk("stray_ack_no_req", {31'b0, a_mem_req}, 32'd0);
    chk("stray_ack_not_busy", {31'b0, a_busy_fetch}, 32'd0);
    a_ack_man = 1'b0;
    a_auto = 1'b1;
    tick();

    // Collision with zero-wait memory: four data grants, then one fetch, repeating.
    a_lat = 0;
    i_addr = 32'h0000_0600; d_addr = 32'h0000_0500; d_we_re = 1'b0; d_mask = 4'hF; d_wdata = 32'h0;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) push_txn(1'b0, 1'b0, 4'hF, 32'h0000_0500, 32'h0);
      push_txn(1'b1, 1'b0, 4'hF, 32'h0000_0600, 32'h0);
    end
    a_i_req = 1'b1;
    a_d_req = 1'b1;
    wait_compl(ncompl + 10, 100);
    a_i_req = 1'b0;
    a_d_req = 1'b0;
    tick(); tick();
    chk("collision_drained", exp_q.size(), 32'd0);

    // Reset while BUSY_D, one cycle before the ack would arrive.
    a_auto = 1'b0;
    a_ack_man = 1'b0;
    d_addr = 32'h0000_0700; i_addr = 32'h0000_0800;
    push_txn(1'b0, 1'b0, 4'hF, 32'h0000_0700, 32'h0);
    a_d_req = 1'b1;
    a_i_req = 1'b1;
    tick();
    chk("rst_test_granted", {31'b0, cur_active}, 32'd1);
    chk("starve_cnt_one", {29'b0, dut_a.starve_cnt_q}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", {31'b0, a_mem_req}, 32'd0);
    chk("rst_starve_cnt", {29'b0, dut_a.starve_cnt_q}, 32'd0);
    cur_active = 1'b0;
    a_d_req = 1'b0;
    a_i_req = 1'b0;
    tick();
    rst = 1'b0;
    a_ack_man = 1'b1;
    #1;
    chk("late_ack_no_valid", {30'b0, a_i_valid, a_d_valid}, 32'd0);
    tick();
    chk("late_ack_idle", {31'b0, a_mem_req}, 32'd0);
    a_ack_man = 1'b0;
    a_auto = 1'b1;
    tick();

    // Strict data priority (limit 0): fetch never granted while data keeps asking.
    begin
      int n;
      b_gi = 0; b_gd = 0; b_dv = 0; b_iv = 0;
      d_addr = 32'h0000_0A00; i_addr = 32'h0000_0900; d_we_re = 1'b0; d_mask = 4'hF;
      b_d_req = 1'b1;
      b_i_req = 1'b1;
      n = 0;
      while (b_dv < 8 && n < 60) begin
        tick();
        if (b_d_valid) chk("b_d_rdata", b_d_rdata, rdfn(32'h0000_0A00));
        n++;
      end
      b_d_req = 1'b0;
      chk("b_data_grants_ge8", {31'b0, b_gd >= 8}, 32'd1);
      chk("b_fetch_starved", b_gi, 32'd0);
      tick();
      chk("b_idle_gap", {31'b0, b_mem_req}, 32'd0);
      tick();
      chk("b_fetch_granted", {30'b0, b_mem_req, b_busy_fetch}, 32'd3);
      chk("b_fetch_addr", b_mem_addr, 32'h0000_0900);
      chk("b_fetch_mask", {28'b0, b_mem_mask}, 32'h0000_000F);
      chk("b_fetch_we", {31'b0, b_mem_we_re}, 32'd0);
      chk("b_fetch_wdata", b_mem_wdata, 32'd0);
      chk("b_fetch_rdata", b_i_rdata, rdfn(32'h0000_0900));
      chk("b_fetch_valid", b_iv, 32'd1);
      b_i_req = 1'b0;
      tick(); tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
